// File: rtl/writeback_queue_pkg.sv
// writeback_queue_pkg: MIPS opcode/funct/rt constants, field extractors, entry kinds and queue entry layout
package writeback_queue_pkg;
   localparam logic [5:0] OPC_SPECIAL = 6'h00;
   localparam logic [5:0] OPC_REGIMM  = 6'h01;
   localparam logic [5:0] OPC_JAL     = 6'h03;
   localparam logic [5:0] OPC_LB      = 6'h20;
   localparam logic [5:0] OPC_LH      = 6'h21;
   localparam logic [5:0] OPC_LW      = 6'h23;
   localparam logic [5:0] OPC_LBU     = 6'h24;
   localparam logic [5:0] OPC_LHU     = 6'h25;
   localparam logic [5:0] FUN_JALR    = 6'h09;
   localparam logic [4:0] RT_BLTZAL   = 5'h10;
   localparam logic [4:0] RT_BGEZAL   = 5'h11;

   // loads occupy the top of the kind range so a single compare identifies them
   localparam logic [2:0] K_ALU  = 3'd0;
   localparam logic [2:0] K_LINK = 3'd1;
   localparam logic [2:0] K_LB   = 3'd2;
   localparam logic [2:0] K_LBU  = 3'd3;
   localparam logic [2:0] K_LH   = 3'd4;
   localparam logic [2:0] K_LHU  = 3'd5;
   localparam logic [2:0] K_LW   = 3'd6;

   typedef struct packed {
      logic [2:0]  kind;
      logic [4:0]  dst;
      logic        we;
      logic [31:0] pc;
      logic [1:0]  off;
      logic [31:0] value;
   } entry_t;

   function automatic logic [5:0] GET_OPC(input logic [31:0] instr);
      return instr[31:26];
   endfunction

   function automatic logic [5:0] GET_FUN(input logic [31:0] instr);
      return instr[5:0];
   endfunction

   function automatic logic [4:0] GET_RT(input logic [31:0] instr);
      return instr[20:16];
   endfunction

   function automatic logic [2:0] decode_kind(input logic [31:0] instr);
      logic [5:0] opc;
      logic       link;
      opc  = GET_OPC(instr);
      link = opc == OPC_JAL
          || (opc == OPC_SPECIAL && GET_FUN(instr) == FUN_JALR)
          || (opc == OPC_REGIMM && (GET_RT(instr) == RT_BGEZAL || GET_RT(instr) == RT_BLTZAL));
      return opc == OPC_LB  ? K_LB  :
             opc == OPC_LBU ? K_LBU :
             opc == OPC_LH  ? K_LH  :
             opc == OPC_LHU ? K_LHU :
             opc == OPC_LW  ? K_LW  :
             link           ? K_LINK : K_ALU;
   endfunction
endpackage

// File: rtl/writeback_queue_load_extract.sv
// load_extract: selects, aligns and extends load data from a memory word and flags misaligned accesses
module load_extract
   import writeback_queue_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic [2:0]  kind_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] word_i,
   output logic [31:0] data_o,
   output logic        misaligned_o
);
   logic [1:0]  b;
   logic [7:0]  by;
   logic [15:0] hw;

   always_comb begin
      b  = BIG_ENDIAN ? 2'd3 - off_i : off_i;
      by = word_i[8*b +: 8];
      hw = b[1] ? word_i[31:16] : word_i[15:0];
      data_o = kind_i == K_LB  ? {{24{by[7]}}, by}  :
               kind_i == K_LBU ? {24'd0, by}        :
               kind_i == K_LH  ? {{16{hw[15]}}, hw} :
               kind_i == K_LHU ? {16'd0, hw}        : word_i;
      misaligned_o = ((kind_i == K_LH || kind_i == K_LHU) && off_i[0])
                  || (kind_i == K_LW && off_i != 2'd0);
   end
endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: in-order write-back queue with load response wait, load extraction and a registered register-file write port
module writeback_queue
   import writeback_queue_pkg::*;
#(
   parameter int          DEPTH       = 4,
   parameter logic [31:0] LINK_OFFSET = 32'd4,
   parameter bit          BIG_ENDIAN  = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_instruction,
   input  logic [31:0]              in_alu_out,
   input  logic [4:0]               in_dst,
   input  logic                     in_we,
   input  logic                     mem_rvalid,
   output logic                     mem_rready,
   input  logic [31:0]              mem_rdata,
   output logic                     wr_en,
   output logic [4:0]               wr_addr,
   output logic [31:0]              wr_data,
   output logic                     misalign_err,
   output logic [31:0]              err_pc,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   entry_t        buf_q [DEPTH];
   logic [AW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q, count_d;
   logic          wr_en_q, misalign_err_q;
   logic [4:0]    wr_addr_q;
   logic [31:0]   wr_data_q, err_pc_q;
   entry_t        head, new_e;
   logic          is_load, push, retire, mis;
   logic [31:0]   ld_data;

   load_extract #(.BIG_ENDIAN(BIG_ENDIAN)) u_extract (
      .kind_i      (head.kind),
      .off_i       (head.off),
      .word_i      (mem_rdata),
      .data_o      (ld_data),
      .misaligned_o(mis)
   );

   // no pass-through: a full queue refuses input even while the head retires
   assign in_ready = count_q < CW'(DEPTH);

   always_comb begin
      head        = buf_q[head_q];
      is_load     = head.kind >= K_LB;
      mem_rready  = count_q != '0 && is_load;
      retire      = count_q != '0 && (!is_load || mem_rvalid);
      push        = in_valid && in_ready;
      count_d     = count_q + CW'(push) - CW'(retire);
      new_e.kind  = decode_kind(in_instruction);
      new_e.dst   = in_dst;
      new_e.we    = in_we;
      new_e.pc    = in_pc;
      new_e.off   = in_alu_out[1:0];
      new_e.value = new_e.kind == K_LINK ? in_pc + LINK_OFFSET : in_alu_out;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         wr_en_q        <= 1'b0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         misalign_err_q <= 1'b0;
         err_pc_q       <= '0;
      end else begin
         if (push) begin
            buf_q[tail_q] <= new_e;
            tail_q        <= tail_q + 1'b1;
         end
         if (retire) begin
            head_q    <= head_q + 1'b1;
            wr_addr_q <= head.dst;
            wr_data_q <= is_load ? ld_data : head.value;
         end
         if (retire && mis) err_pc_q <= head.pc;
         count_q        <= count_d;
         wr_en_q        <= retire && head.we && head.dst != 5'd0 && !mis;
         misalign_err_q <= retire && mis;
      end
   end

   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign misalign_err = misalign_err_q;
   assign err_pc       = err_pc_q;
   assign count        = count_q;
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed scoreboard bench driving little- and big-endian queue instances in lockstep
module tb_writeback_queue;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_we, mem_rvalid;
   logic [31:0] in_pc, in_instruction, in_alu_out, mem_rdata;
   logic [4:0]  in_dst;
   logic        in_ready, mem_rready, wr_en, misalign_err;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data, err_pc;
   logic [2:0]  count;
   logic        be_in_ready, be_mem_rready, be_wr_en, be_misalign_err;
   logic [4:0]  be_wr_addr;
   logic [31:0] be_wr_data, be_err_pc;
   logic [2:0]  be_count;

   typedef struct {
      logic        err;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] data_be;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   writeback_queue #(.DEPTH(4), .LINK_OFFSET(32'd8), .BIG_ENDIAN(1'b0)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_instruction(in_instruction), .in_alu_out(in_alu_out), .in_dst(in_dst), .in_we(in_we),
      .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .misalign_err(misalign_err), .err_pc(err_pc), .count(count)
   );

   writeback_queue #(.DEPTH(4), .LINK_OFFSET(32'd8), .BIG_ENDIAN(1'b1)) dut_be (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(be_in_ready), .in_pc(in_pc),
      .in_instruction(in_instruction), .in_alu_out(in_alu_out), .in_dst(in_dst), .in_we(in_we),
      .mem_rvalid(mem_rvalid), .mem_rready(be_mem_rready), .mem_rdata(mem_rdata), .wr_en(be_wr_en),
      .wr_addr(be_wr_addr), .wr_data(be_wr_data), .misalign_err(be_misalign_err), .err_pc(be_err_pc),
      .count(be_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic void expw(input logic [4:0] addr, input logic [31:0] d, input logic [31:0] d_be);
      exp_q.push_back('{1'b0, addr, d, d_be});
   endfunction

   function automatic void expe(input logic [31:0] pc);
      exp_q.push_back('{1'b1, 5'd0, pc, pc});
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] alu,
                       input logic [4:0] dst, input logic we);
      in_valid = 1'b1; in_pc = pc; in_instruction = instr; in_alu_out = alu; in_dst = dst; in_we = we;
      for (int i = 0; i < 50 && !in_ready; i++) step();
      if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d);
      mem_rvalid = 1'b1; mem_rdata = d;
      for (int i = 0; i < 50 && !mem_rready; i++) step();
      if (!mem_rready) chk("resp_timeout", {31'd0, mem_rready}, 32'd1);
      step();
      mem_rvalid = 1'b0;
   endtask

   // scoreboard: every write/error pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (reset_n === 1'b1 && (wr_en || misalign_err || be_wr_en || be_misalign_err)) begin
         chk("wr_and_err_together", {31'd0, wr_en & misalign_err}, 32'd0);
         chk("be_pulse_match", {30'd0, be_wr_en, be_misalign_err}, {30'd0, wr_en, misalign_err});
         if (exp_q.size() == 0) begin
            chk("unexpected_output", {25'd0, wr_en, misalign_err, wr_addr}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", {30'd0, wr_en, misalign_err}, {30'd0, !e.err, e.err});
            if (e.err) begin
               chk("err_pc", err_pc, e.data);
               chk("be_err_pc", be_err_pc, e.data_be);
            end else begin
               chk("wr_addr", {27'd0, wr_addr}, {27'd0, e.addr});
               chk("wr_data", wr_data, e.data);
               chk("be_wr_data", be_wr_data, e.data_be);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_instruction = '0; in_alu_out = '0;
      in_dst = '0; in_we = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) step();
      reset_n = 1'b1;
      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_mem_rready", {31'd0, mem_rready}, 32'd0);
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
      chk("rst_err_pc", err_pc, 32'd0);

      // ADDU: write appears exactly two cycles after the accepting cycle
      expw(5'd8, 32'd5, 32'd5);
      send(32'h0040_0000, 32'h0000_0021, 32'd5, 5'd8, 1'b1);
      chk("addu_early_wr_en", {31'd0, wr_en}, 32'd0);
      chk("addu_count", {29'd0, count}, 32'd1);
      step();
      chk("addu_wr_en", {31'd0, wr_en}, 32'd1);
      chk("addu_count_after", {29'd0, count}, 32'd0);
      step();
      chk("addu_pulse_one_cycle", {31'd0, wr_en}, 32'd0);

      // link forms and a non-link REGIMM branch, back to back
      expw(5'd31, 32'h0040_0018, 32'h0040_0018);
      send(32'h0040_0010, 32'h0C10_0004, 32'h0, 5'd31, 1'b1);
      expw(5'd31, 32'h0040_0028, 32'h0040_0028);
      send(32'h0040_0020, 32'h0000_F809, 32'h0, 5'd31, 1'b1);
      expw(5'd31, 32'h0040_0038, 32'h0040_0038);
      send(32'h0040_0030, 32'h0411_0003, 32'hDEAD, 5'd31, 1'b1);
      expw(5'd31, 32'h0040_0048, 32'h0040_0048);
      send(32'h0040_0040, 32'h0410_0003, 32'hBEEF, 5'd31, 1'b1);
      expw(5'd5, 32'h1234, 32'h1234);
      send(32'h0040_0050, 32'h0401_0003, 32'h1234, 5'd5, 1'b1);

      // sub-word loads on word 0x1280_FF34
      expw(5'd10, 32'hFFFF_FF80, 32'hFFFF_FFFF);
      send(32'h0040_0060, 32'h8000_0000, 32'h1000_0002, 5'd10, 1'b1);
      respond(32'h1280_FF34);
      expw(5'd11, 32'h0000_0080, 32'h0000_00FF);
      send(32'h0040_0064, 32'h9000_0000, 32'h1000_0002, 5'd11, 1'b1);
      respond(32'h1280_FF34);
      expw(5'd12, 32'h0000_1280, 32'hFFFF_FF34);
      send(32'h0040_0068, 32'h8400_0000, 32'h1000_0002, 5'd12, 1'b1);
      respond(32'h1280_FF34);
      expw(5'd13, 32'h0000_FF34, 32'h0000_1280);
      send(32'h0040_006C, 32'h9400_0000, 32'h1000_0000, 5'd13, 1'b1);
      respond(32'h1280_FF34);
      expw(5'd14, 32'h1280_FF34, 32'h1280_FF34);
      send(32'h0040_0070, 32'h8C00_0000, 32'h1000_0000, 5'd14, 1'b1);
      respond(32'h1280_FF34);
      expw(5'd16, 32'hFFFF_FFFF, 32'hFFFF_FF80);
      send(32'h0040_0074, 32'h8000_0000, 32'h1000_0001, 5'd16, 1'b1);
      respond(32'h1280_FF34);
      expw(5'd17, 32'h0000_0012, 32'h0000_0034);
      send(32'h0040_0078, 32'h9000_0000, 32'h1000_0003, 5'd17, 1'b1);
      respond(32'h1280_FF34);

      // misaligned LH: response consumed, error pulse instead of a write
      expe(32'h0040_0100);
      send(32'h0040_0100, 32'h8400_0000, 32'h1000_0001, 5'd15, 1'b1);
      respond(32'h1280_FF34);
      chk("mis_err", {31'd0, misalign_err}, 32'd1);
      chk("mis_wr_en", {31'd0, wr_en}, 32'd0);
      chk("mis_err_pc", err_pc, 32'h0040_0100);
      chk("mis_count", {29'd0, count}, 32'd0);
      chk("mis_rready", {31'd0, mem_rready}, 32'd0);
      step();
      chk("mis_pulse_one_cycle", {31'd0, misalign_err}, 32'd0);
      expe(32'h0040_0200);
      send(32'h0040_0200, 32'h8C00_0000, 32'h1000_0002, 5'd15, 1'b1);
      respond(32'h0);

      // stalled LW at head while ALU ops fill the queue
      expw(5'd9, 32'hCAFE_BABE, 32'hCAFE_BABE);
      send(32'h0040_0300, 32'h8C00_0000, 32'h2000_0000, 5'd9, 1'b1);
      for (int i = 1; i <= 3; i++) begin
         expw(5'(20 + i), 32'h100 + i, 32'h100 + i);
         send(32'h0040_0300 + 4 * i, 32'h0000_0021, 32'h100 + i, 5'(20 + i), 1'b1);
      end
      chk("full_count", {29'd0, count}, 32'd4);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("full_mem_rready", {31'd0, mem_rready}, 32'd1);
      expw(5'd24, 32'h104, 32'h104);
      in_valid = 1'b1; in_pc = 32'h0040_0310; in_instruction = 32'h0000_0021;
      in_alu_out = 32'h104; in_dst = 5'd24; in_we = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stall_count", {29'd0, count}, 32'd4);
         chk("stall_wr_en", {31'd0, wr_en}, 32'd0);
      end
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_BABE;
      step();
      mem_rvalid = 1'b0;
      chk("drain_lw_count", {29'd0, count}, 32'd3);
      chk("drain_lw_wr_en", {31'd0, wr_en}, 32'd1);
      chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      chk("drain_push_pop_count", {29'd0, count}, 32'd3);
      for (int i = 2; i >= 0; i--) begin
         step();
         chk("drain_count", {29'd0, count}, 32'(i));
         chk("drain_wr_en", {31'd0, wr_en}, 32'd1);
      end
      step();
      chk("drain_idle", {31'd0, wr_en}, 32'd0);

      // write to $zero retires silently
      send(32'h0040_0400, 32'h0000_0021, 32'h77, 5'd0, 1'b1);
      chk("zero_count", {29'd0, count}, 32'd1);
      step();
      chk("zero_count_after", {29'd0, count}, 32'd0);
      chk("zero_wr_en", {31'd0, wr_en}, 32'd0);
      step();

      // reset with three stalled loads queued
      for (int i = 1; i <= 3; i++) send(32'h0040_0500, 32'h8C00_0000, 32'h3000_0000, 5'(i), 1'b1);
      chk("pre_rst_count", {29'd0, count}, 32'd3);
      reset_n = 1'b0;
      step();
      chk("mid_rst_count", {29'd0, count}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_mem_rready", {31'd0, mem_rready}, 32'd0);
      chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("mid_rst_wr_addr", {27'd0, wr_addr}, 32'd0);
      chk("mid_rst_wr_data", wr_data, 32'd0);
      chk("mid_rst_misalign", {31'd0, misalign_err}, 32'd0);
      chk("mid_rst_err_pc", err_pc, 32'd0);
      reset_n = 1'b1;

      expw(5'd7, 32'h42, 32'h42);
      send(32'h0040_0600, 32'h0000_0021, 32'h42, 5'd7, 1'b1);
      repeat (4) step();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/writeback_queue.md
# writeback_queue

In-order write-back stage for the MIPS pipeline: a parametrised, buffered successor to the single-cycle write-data selector. It accepts retiring instructions from the MEM stage through a valid/ready handshake and holds them in a DEPTH-entry in-order queue. It waits on a variable-latency memory read response for loads, then extracts, aligns and sign- or zero-extends the load data. It drives a single registered register-file write port and flags misaligned loads.

## Interface
- DEPTH, 4: queue entries, power of two, at least 2.
- LINK_OFFSET, 4: added to the pc for link writes (JAL, JALR, BGEZAL, BLTZAL); 8 for delay-slot builds.
- BIG_ENDIAN, 0: byte-lane order for sub-word loads.
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  queue can accept an instruction.
- in_pc  in  32  pc of the instruction.
- in_instruction  in  32  raw instruction word.
- in_alu_out  in  32  ALU result; the effective address for loads.
- in_dst  in  5  destination register, already resolved by decode.
- in_we  in  1  instruction writes a register.
- mem_rvalid  in  1  memory read response valid; responses arrive in load order.
- mem_rready  out  1  head entry consumes the response.
- mem_rdata  in  32  aligned memory word.
- wr_en  out  1  register-file write strobe.
- wr_addr  out  5  register written.
- wr_data  out  32  data written.
- misalign_err  out  1  one-cycle pulse for a misaligned load.
- err_pc  out  32  pc of the faulting load, valid with misalign_err.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Enqueue on in_valid && in_ready. Each entry stores: kind (ALU / LINK / LB / LBU / LH / LHU / LW), dst, we, pc, off = in_alu_out[1:0], and value.
  - value = in_pc + LINK_OFFSET for LINK, otherwise in_alu_out.
- Kind decode:
  - opcodes LB, LBU, LH, LHU and LW are loads.
  - JAL is LINK.
  - SPECIAL with funct JALR is LINK.
  - REGIMM with rt BGEZAL or BLTZAL is LINK.
  - Everything else is ALU.
- Head retire condition:
  - ALU or LINK entries retire unconditionally.
  - Load entries retire only on mem_rvalid && mem_rready.
  - mem_rready = queue non-empty && head is a load.
- Load extraction, with byte index b = off when BIG_ENDIAN=0, and b = 3-off otherwise:
  - LB: sign-extend byte b.
  - LBU: zero-extend byte b.
  - LH: sign-extend halfword b[1].
  - LHU: zero-extend halfword b[1].
  - LW: the full word.
- Misaligned loads are LH/LHU with off[0]=1, or LW with off≠0.
  - The entry still consumes its response.
  - wr_en stays 0; misalign_err=1 and err_pc=pc are asserted instead.
- wr_en = we && dst≠0 && !misaligned. Register $zero is never written, but the entry still retires.

## Timing
- Reset (reset_n=0 at a clock edge):
  - queue empty, count=0.
  - wr_en=0, wr_addr=0, wr_data=0, misalign_err=0, err_pc=0.
  - in_ready=1 and mem_rready=0 from the first cycle after reset.
- Reset mid-operation discards all entries. Responses still pending in memory are the memory side's responsibility.
- in_ready = count < DEPTH, combinational from count. There is no pass-through when full: a full queue refuses input even if the head retires in the same cycle.
- Simultaneous enqueue and retire leaves count unchanged. Pointers wrap modulo DEPTH.
- An entry enqueued at edge N becomes head no earlier than cycle N+1. If it retires in cycle N+1, wr_en / misalign_err are high during N+2, because all write-port and error outputs are registered.
- Minimum latency from accept to write is 2 cycles; sustained throughput is 1 retire per cycle.
- A load at head with mem_rvalid=0 stalls the head; the queue keeps accepting input until full.
- wr_en and misalign_err are high for exactly 1 cycle per retired entry. They are never high together.

## Structure
- The shared package (the existing ISA include) supplies:
  - opcode, funct and rt constants.
  - GET_OPC / GET_FUN / GET_RT field extractors.
  - the entry-kind enumeration (3-bit localparams).
- Sub-module `load_extract` is combinational: inputs kind, off, word and BIG_ENDIAN; outputs data and misaligned. It is instantiated once at the queue head.
- The queue is a register array with head/tail pointers and a count register, all in this module.

## Test plan
- ADDU retiring with alu_out=0x0000_0005, dst=8 on an empty queue -> wr_en=1, wr_addr=8, wr_data=5 exactly 2 cycles after accept.
- JAL at pc=0x0040_0010 with LINK_OFFSET=8 -> wr_addr=31, wr_data=0x0040_0018.
- LB addr off=2, mem_rdata=0x1280_FF34, BIG_ENDIAN=0 -> wr_data=0xFFFF_FF80.
  - Same case as LBU -> wr_data=0x0000_0080.
  - Same case as LB with BIG_ENDIAN=1 -> wr_data=0xFFFF_FFFF.
- LW at head with mem_rvalid held low for 5 cycles while 4 ALU ops arrive (DEPTH=4):
  - in_ready drops once 4 entries are queued.
  - Responses then retire in order, one per cycle, with count returning to 0.
- LH with off=1 at pc=0x0040_0100 -> response consumed, wr_en=0, misalign_err=1, err_pc=0x0040_0100.
- ADDU with dst=0 -> retires, count decrements, wr_en stays 0.
- Reset asserted with 3 entries queued -> next cycle count=0, in_ready=1, all outputs 0.
